// File: rtl/weight_pref_ctrl.sv
// Double-buffered weight prefetch sequencer: 96-word tile SRAM->shadow bank, start->swap 99 cycles.
// en=0 stalls reads/FSM (in-flight write completes); swap waits on SA release. WPREF_PERF_CNT_EN adds stall/tile counters.
module weight_pref_ctrl #(
    parameter int N      = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 8,
    parameter int WG     = 3,
    parameter int ADDR_W = 10,
    localparam int RW    = $clog2(ROWS),
    localparam int CLW   = $clog2(COLS),
    localparam int WGW   = $clog2(WG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              sa_done,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [2*N-1:0]    sram_rdata,
    output logic              wr_en,
    output logic [RW-1:0]     wr_row,
    output logic [CLW-1:0]    wr_col,
    output logic [WGW-1:0]    wr_wg,
    output logic [2*N-1:0]    wr_data,
    output logic              buf_select,
    output logic              weight_valid,
    output logic              busy,
    output logic              swap
`ifdef WPREF_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       tile_cnt
`endif
);

    localparam int TOTAL = ROWS * COLS * WG;
    localparam int CW    = $clog2(TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [CW-1:0]       r_cnt;
    logic [RW-1:0]       r_row;
    logic [CLW-1:0]      r_col;
    logic [WGW-1:0]      r_wg;
    logic                r_p1_vld;
    logic [RW-1:0]       r_p1_row;
    logic [CLW-1:0]      r_p1_col;
    logic [WGW-1:0]      r_p1_wg;
    logic                r_wr_en;
    logic [RW-1:0]       r_wr_row;
    logic [CLW-1:0]      r_wr_col;
    logic [WGW-1:0]      r_wr_wg;
    logic [2*N-1:0]      r_wr_data;
    logic                r_buf_sel;
    logic                r_wv;
    logic                r_done_pend;
    logic                r_swap;

    logic w_start;
    logic w_rd_en;
    logic w_swap;
    logic w_last;

    assign w_start = en && (r_state == S_IDLE) && start;
    assign w_rd_en = en && (r_state == S_FETCH);
    assign w_last  = (r_cnt == CW'(TOTAL - 1));
    // A pending release or an sa_done in the same cycle both free the active bank.
    assign w_swap  = en && (r_state == S_READY) && (!r_wv || r_done_pend || sa_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)          w_next = S_FETCH;
            S_FETCH: if (w_rd_en && w_last) w_next = S_DRAIN;
            S_DRAIN: if (en)               w_next = S_READY;
            S_READY: if (w_swap)           w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sram_rd_en = w_rd_en;
        sram_addr  = w_rd_en ? (r_base + ADDR_W'(r_cnt)) : '0;
        busy       = (r_state != S_IDLE);
    end

    // Tile counters: wg fastest, then column, then row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_cnt  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_wg   <= '0;
        end else if (w_start) begin
            r_base <= base_addr;
            r_cnt  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_wg   <= '0;
        end else if (w_rd_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_wg == WGW'(WG - 1)) begin
                r_wg <= '0;
                if (r_col == CLW'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_wg <= r_wg + 1'b1;
            end
        end
    end

    // Write pipe advances regardless of en so the read already issued lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_vld  <= 1'b0;
            r_p1_row  <= '0;
            r_p1_col  <= '0;
            r_p1_wg   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_wg   <= '0;
            r_wr_data <= '0;
        end else begin
            r_p1_vld <= w_rd_en;
            if (w_rd_en) begin
                r_p1_row <= r_row;
                r_p1_col <= r_col;
                r_p1_wg  <= r_wg;
            end
            r_wr_en <= r_p1_vld;
            if (r_p1_vld) begin
                r_wr_row  <= r_p1_row;
                r_wr_col  <= r_p1_col;
                r_wr_wg   <= r_p1_wg;
                r_wr_data <= sram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_sel   <= 1'b0;
            r_wv        <= 1'b0;
            r_done_pend <= 1'b0;
            r_swap      <= 1'b0;
        end else begin
            r_swap <= w_swap;
            if (w_swap) begin
                r_buf_sel   <= ~r_buf_sel;
                r_wv        <= 1'b1;
                r_done_pend <= 1'b0;
            end else if (sa_done) begin
                r_done_pend <= 1'b1;
                r_wv        <= 1'b0;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_row       = r_wr_row;
    assign wr_col       = r_wr_col;
    assign wr_wg        = r_wr_wg;
    assign wr_data      = r_wr_data;
    assign buf_select   = r_buf_sel;
    assign weight_valid = r_wv;
    assign swap         = r_swap;

`ifdef WPREF_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_tile_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_tile_cnt  <= '0;
        end else begin
            if ((r_state == S_READY) && !w_swap && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_swap)
                r_tile_cnt <= r_tile_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign tile_cnt  = r_tile_cnt;
`endif

endmodule

// File: tb/tb_weight_pref_ctrl.sv
// Randomized bench for weight_pref_ctrl: SRAM model, tile-level reference of address/write streams and swap timing.
module tb_weight_pref_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int WG    = 3;
    localparam int TOTAL = ROWS * COLS * WG;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        start;
    logic [9:0]  base_addr;
    logic        sa_done;
    logic        sram_rd_en;
    logic [9:0]  sram_addr;
    logic [15:0] sram_rdata = '0;
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [2:0]  wr_col;
    logic [1:0]  wr_wg;
    logic [15:0] wr_data;
    logic        buf_select;
    logic        weight_valid;
    logic        busy;
    logic        swap;
`ifdef WPREF_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] tile_cnt;
`endif

    weight_pref_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .start        (start),
        .base_addr    (base_addr),
        .sa_done      (sa_done),
        .sram_rd_en   (sram_rd_en),
        .sram_addr    (sram_addr),
        .sram_rdata   (sram_rdata),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_wg        (wr_wg),
        .wr_data      (wr_data),
        .buf_select   (buf_select),
        .weight_valid (weight_valid),
        .busy         (busy),
        .swap         (swap)
`ifdef WPREF_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .tile_cnt     (tile_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference state: tile in progress, bank the SA owns, whether the SA still holds it.
    int  m_base   = 0;
    int  m_rd_idx = 0;
    int  m_wr_idx = 0;
    bit  m_bank   = 1'b0;
    bit  m_in_use = 1'b0;
    int  m_tiles  = 0;
    int  m_stall  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    always @(posedge clk) begin
        if (sram_rd_en) sram_rdata <= mem[sram_addr];
    end

    // Stream monitor: read k addresses base+k; write k lands at (k/24, (k/3)%8, k%3).
    always @(negedge clk) begin
        if (reset_n) begin
            if (!en) chk("rd_gated", sram_rd_en, 0);
            if (sram_rd_en) begin
                chk("rd_addr", sram_addr, (m_base + m_rd_idx) % 1024);
                m_rd_idx++;
            end
            if (wr_en) begin
                chk("wr_row",  wr_row,  m_wr_idx / (COLS * WG));
                chk("wr_col",  wr_col,  (m_wr_idx / WG) % COLS);
                chk("wr_wg",   wr_wg,   m_wr_idx % WG);
                chk("wr_data", wr_data, mem[(m_base + m_wr_idx) % 1024]);
                m_wr_idx++;
            end
        end
    end

    task automatic run_tile(input int base, input int gap_at, input int gap_len,
                            input int sa_at, input int busy_start_at);
        int n;
        int hold;
        int exp_cyc;
        bit wait_sa;
        bit got;
        wait_sa  = m_in_use && (sa_at == 0);
        hold     = $urandom_range(1, 6);
        exp_cyc  = 99 + gap_len + (wait_sa ? hold : 0);
        m_base   = base;
        m_rd_idx = 0;
        m_wr_idx = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'(base);
        en        = 1'b1;
        sa_done   = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 400 && !got) begin
            @(posedge clk); n++; #1;
            start     = (n == busy_start_at);
            base_addr = 10'($urandom);
            en        = !(n >= gap_at && n < gap_at + gap_len);
            sa_done   = (n == sa_at) || (wait_sa && n == 98 + gap_len + hold);
            @(negedge clk);
            if (sa_at != 0 && n == sa_at + 1) chk("wv_clr_fetch", weight_valid, 0);
            if (wait_sa && n == 98 + gap_len) begin
                chk("hold_busy", busy, 1);
                chk("hold_wv", weight_valid, 1);
                chk("hold_buf", buf_select, m_bank);
            end
            if (swap) got = 1'b1;
        end
        start   = 1'b0;
        sa_done = 1'b0;
        en      = 1'b1;
        if (!got) chk("swap_timeout", 0, 1);
        chk("swap_cycle", n, exp_cyc);
        chk("swap_buf", buf_select, !m_bank);
        chk("swap_wv", weight_valid, 1);
        chk("swap_idle", busy, 0);
        chk("n_reads", m_rd_idx, TOTAL);
        chk("n_writes", m_wr_idx, TOTAL);
        m_bank   = !m_bank;
        m_in_use = 1'b1;
        m_tiles++;
        if (wait_sa) m_stall += hold;
`ifdef WPREF_PERF_CNT_EN
        chk("tile_cnt", tile_cnt, m_tiles);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic idle_release();
        @(posedge clk); #1 sa_done = 1'b1;
        @(posedge clk); #1 sa_done = 1'b0;
        @(negedge clk);
        chk("wv_clr_idle", weight_valid, 0);
        chk("idle_buf", buf_select, m_bank);
        m_in_use = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, sram_rd_en, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_wr"}, {wr_en, wr_row, wr_col, wr_wg, wr_data}, 0);
        chk({tag, "_bank"}, {buf_select, weight_valid}, 0);
        chk({tag, "_busy_swap"}, {busy, swap}, 0);
`ifdef WPREF_PERF_CNT_EN
        chk({tag, "_perf"}, {stall_cnt, tile_cnt}, 0);
`endif
    endtask

    task automatic reset_mid_fetch(input int base);
        m_base   = base;
        m_rd_idx = 0;
        m_wr_idx = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'(base);
        for (int n = 1; n <= 51; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_bank   = 1'b0;
        m_in_use = 1'b0;
        m_tiles  = 0;
        m_stall  = 0;
        @(negedge clk);
        check_all_zero("rst_after");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        reset_n   = 1'b0;
        en        = 1'b0;
        start     = 1'b0;
        sa_done   = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset_n = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        run_tile(10'h040, 0, 0, 0, 0);
        run_tile(int'($urandom_range(0, 1023)), 0, 0, 0, 30);
        run_tile(int'($urandom_range(0, 1023)), 0, 0, 40, 0);
        run_tile(int'($urandom_range(0, 1023)), 21, 5, 0, 0);
        run_tile(10'h3F0, 0, 0, 0, 0);
        idle_release();
        run_tile(int'($urandom_range(0, 1023)), 0, 0, 0, 0);
        reset_mid_fetch(int'($urandom_range(0, 1023)));
        run_tile(int'($urandom_range(0, 1023)), 0, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 3) == 0) idle_release();
            run_tile(int'($urandom_range(0, 1023)),
                     int'($urandom_range(1, 96)),
                     int'($urandom_range(0, 6)),
                     ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 90)),
                     int'($urandom_range(2, 90)));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
